// File: rtl/add_one_arbiter.sv
// add_one_arbiter: shares one add_one datapath among N_REQ requesters.
// Operands are granted round-robin; the requester index of every issued
// operation is queued in an in-order tag FIFO so that each result (which
// add_one returns strictly in issue order) is steered back to its owner.

// Per-lane return steering: lane IDX sees the result only when it owns the
// FIFO head tag.
module add_one_arbiter_lane #(
  parameter int IDX = 0,
  parameter int TW  = 2
) (
  input  logic [TW-1:0] i_head,
  input  logic          i_empty,
  input  logic          i_ret_vld,
  output logic          o_ret_vld
);
  assign o_ret_vld = i_ret_vld & ~i_empty & (i_head == TW'(IDX));
endmodule

module add_one_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_x_vld,
  input  logic [N_REQ*DW-1:0]            req_x_data,
  output logic [N_REQ-1:0]               req_x_busy,
  output logic [N_REQ-1:0]               req_return_vld,
  output logic [DW-1:0]                  req_return_data,
  input  logic [N_REQ-1:0]               req_return_busy,
  output logic                           add_one_x_vld,
  output logic [DW-1:0]                  add_one_x_data,
  input  logic                           add_one_x_busy,
  input  logic                           add_one_return_vld,
  input  logic [DW-1:0]                  add_one_return_data,
  output logic                           add_one_return_busy,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding
);
  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_grant, w_grant_nxt;
  logic [TW-1:0] r_rr_ptr, w_rr_nxt;
  logic [TW-1:0] w_pick, w_idx;
  logic          w_any;

  logic [TW-1:0] r_tag [TAG_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop, w_empty, w_full;
  logic [TW-1:0] w_head;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Walking downward lets the smallest offset win.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_idx  = r_rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = TW'((int'(r_rr_ptr) + k) % N_REQ);
      if (req_x_vld[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Issue FSM next state and operand-side outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_nxt      = r_rr_ptr;
    w_push        = 1'b0;
    add_one_x_vld = 1'b0;
    req_x_busy    = '1;
    case (r_state)
      IDLE: begin
        // full check uses the registered count: a same-cycle pop does not help
        if (w_any && !w_full) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        add_one_x_vld       = 1'b1;
        req_x_busy[r_grant] = add_one_x_busy;
        if (!add_one_x_busy) begin
          w_push      = 1'b1;
          w_rr_nxt    = (r_grant == TW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign add_one_x_data = req_x_data[int'(r_grant)*DW +: DW];

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Tag storage; contents are only meaningful while the count says so.
  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wptr] <= r_grant;
  end

  // Tag FIFO pointers and occupancy; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_head  = r_tag[r_rptr];

  // An orphan result (FIFO empty) is held off rather than dropped.
  assign add_one_return_busy = w_empty | req_return_busy[w_head];
  assign w_pop               = add_one_return_vld & ~add_one_return_busy;
  assign req_return_data     = add_one_return_data;
  assign outstanding         = r_count;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    add_one_arbiter_lane #(.IDX(i), .TW(TW)) u_lane (
      .i_head    (w_head),
      .i_empty   (w_empty),
      .i_ret_vld (add_one_return_vld),
      .o_ret_vld (req_return_vld[i])
    );
  end
endmodule

// File: tb/tb_add_one_arbiter.sv
// Bench for add_one_arbiter: a behavioural add_one and requester environment,
// directed scenarios followed by a randomized soak.
module tb_add_one_arbiter;
  localparam int N_REQ = 4;
  localparam int DW = 32;
  localparam int TAG_DEPTH = 4;
  localparam int TW = 2;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [N_REQ-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_REQ-1:0] req_x_vld = '0;
  logic [N_REQ*DW-1:0] req_x_data = '0;
  logic [N_REQ-1:0] req_x_busy;
  logic [N_REQ-1:0] req_return_vld;
  logic [DW-1:0] req_return_data;
  logic [N_REQ-1:0] req_return_busy = '0;
  logic add_one_x_vld;
  logic [DW-1:0] add_one_x_data;
  logic add_one_x_busy = 1'b0;
  logic add_one_return_vld = 1'b0;
  logic [DW-1:0] add_one_return_data = '0;
  logic add_one_return_busy;
  logic [CW-1:0] outstanding;

  add_one_arbiter #(.N_REQ(N_REQ), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_x_vld(req_x_vld), .req_x_data(req_x_data), .req_x_busy(req_x_busy),
    .req_return_vld(req_return_vld), .req_return_data(req_return_data),
    .req_return_busy(req_return_busy),
    .add_one_x_vld(add_one_x_vld), .add_one_x_data(add_one_x_data),
    .add_one_x_busy(add_one_x_busy),
    .add_one_return_vld(add_one_return_vld), .add_one_return_data(add_one_return_data),
    .add_one_return_busy(add_one_return_busy),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // environment knobs, written by the directed sequence
  logic rst_req = 1'b1;
  logic rnd = 1'b0;
  logic xb_force = 1'b0;
  logic [N_REQ-1:0] rb_force = '0;

  // requester operand queues, add_one pipeline, and the in-order model
  logic [DW-1:0] rq [N_REQ][$];
  logic [DW-1:0] sink_q [$];
  logic ret_on = 1'b0;
  logic [TW-1:0] il [$];       // lanes of operations in flight, issue order
  logic [DW-1:0] iv [$];       // expected result for each in-flight op
  logic [TW-1:0] il_log [$];   // every issue, in order
  logic [TW-1:0] rl [$];       // lane of each delivered result
  logic [DW-1:0] rv [$];       // value of each delivered result

  logic xfer_x, xfer_r, gfound, exp_rb;
  logic [TW-1:0] gl;
  logic [N_REQ-1:0] exp_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Drive all DUT inputs on the falling edge, then score what the coming
  // rising edge will transfer.
  always @(negedge clk) begin
    rst = rst_req;
    if (rst) begin
      sink_q.delete(); il.delete(); iv.delete();
      ret_on = 1'b0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      req_x_vld[i] = (rq[i].size() > 0);
      req_x_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end
    add_one_x_busy = xb_force | (rnd && ($urandom_range(0, 2) == 0));
    if (!ret_on && sink_q.size() > 0 && !(rnd && ($urandom_range(0, 3) == 0))) ret_on = 1'b1;
    add_one_return_vld = ret_on;
    add_one_return_data = ret_on ? sink_q[0] : '0;
    req_return_busy = rb_force | (rnd ? N_REQ'($urandom) : '0);
    #1;
    if (!rst) begin
      xfer_x = add_one_x_vld && !add_one_x_busy;
      xfer_r = add_one_return_vld && !add_one_return_busy;
      chk("outstanding", outstanding, il.size());
      chk("ret_vld_onehot", $onehot0(req_return_vld), 1);
      exp_rv = '0;
      exp_rb = 1'b1;
      if (il.size() > 0) begin
        exp_rb = req_return_busy[il[0]];
        if (add_one_return_vld) exp_rv = N_REQ'(1) << il[0];
      end
      chk("ret_vld_steer", req_return_vld, exp_rv);
      chk("ret_busy", add_one_return_busy, exp_rb);
      if (xfer_x) begin
        chk("x_busy_onehot", $onehot(~req_x_busy), 1);
        gfound = 1'b0; gl = '0;
        for (int i = 0; i < N_REQ; i++) if (!req_x_busy[i]) begin gfound = 1'b1; gl = TW'(i); end
        if (gfound && rq[gl].size() > 0) begin
          chk("issue_data", add_one_x_data, rq[gl][0]);
          chk("issue_room", il.size() < TAG_DEPTH, 1);
          il.push_back(gl);
          iv.push_back(rq[gl][0] + 1);
          il_log.push_back(gl);
          sink_q.push_back(add_one_x_data + 1);
          void'(rq[gl].pop_front());
        end else chk("issue_owner_valid", 0, 1);
      end else chk("x_busy_idle", req_x_busy, ONES);
      if (xfer_r) begin
        if (il.size() > 0) begin
          chk("ret_data", req_return_data, iv[0]);
          rl.push_back(il[0]);
          rv.push_back(req_return_data);
          void'(il.pop_front());
          void'(iv.pop_front());
        end else chk("ret_orphan_accepted", 1, 0);
        void'(sink_q.pop_front());
        ret_on = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    il_log.delete(); rl.delete(); rv.delete();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0;
    step();
    clear_logs();
  endtask

  int total;
  logic [DW-1:0] val;

  initial begin
    // reset state
    step(); step();
    chk("rst_x_vld", add_one_x_vld, 0);
    chk("rst_x_busy", req_x_busy, ONES);
    chk("rst_ret_vld", req_return_vld, 0);
    chk("rst_ret_busy", add_one_return_busy, 1);
    chk("rst_outstanding", outstanding, 0);
    rst_req = 1'b0;
    step();
    clear_logs();

    // 1: single op, one-cycle grant latency, occupancy 0->1->0
    rq[1].push_back(32'd5);
    step();
    chk("t1_req_vld", req_x_vld[1], 1);
    chk("t1_x_vld_low", add_one_x_vld, 0);
    step();
    chk("t1_x_vld", add_one_x_vld, 1);
    chk("t1_x_data", add_one_x_data, 5);
    chk("t1_occ0", outstanding, 0);
    step();
    chk("t1_occ1", outstanding, 1);
    chk("t1_ret_lane", req_return_vld, 4'b0010);
    chk("t1_ret_data", req_return_data, 6);
    step();
    chk("t1_occ_end", outstanding, 0);
    chk("t1_delivered", rl.size(), 1);

    // 2: round-robin among 0, 2, 3
    do_reset();
    rq[0].push_back(32'd10); rq[0].push_back(32'd40);
    rq[2].push_back(32'd20); rq[3].push_back(32'd30);
    for (int k = 0; k < 200 && !(rl.size() >= 4); k++) step();
    chk("t2_timeout", rl.size() >= 4, 1);
    if (il_log.size() >= 4 && rv.size() >= 3) begin
      chk("t2_order0", il_log[0], 0);
      chk("t2_order1", il_log[1], 2);
      chk("t2_order2", il_log[2], 3);
      chk("t2_order3", il_log[3], 0);
      chk("t2_ret0", {rl[0], rv[0]}, {2'd0, 32'd11});
      chk("t2_ret1", {rl[1], rv[1]}, {2'd2, 32'd21});
      chk("t2_ret2", {rl[2], rv[2]}, {2'd3, 32'd31});
    end

    // 3: returns stalled, tag FIFO fills and parks the issuer
    do_reset();
    rb_force = ONES;
    for (int k = 0; k < 6; k++) rq[0].push_back(32'(100 + k));
    repeat (40) step();
    chk("t3_issues_full", il_log.size(), 4);
    chk("t3_occ_full", outstanding, 4);
    chk("t3_parked", add_one_x_vld, 0);
    chk("t3_req_busy", req_x_busy[0], 1);
    rb_force = '0;
    for (int k = 0; k < 200 && !(rl.size() >= 6); k++) step();
    chk("t3_timeout", rl.size() >= 6, 1);
    chk("t3_issues_all", il_log.size(), 6);
    if (rv.size() >= 6) chk("t3_last", rv[5], 106);

    // 4: operand stall holds grant and data; wrap to zero
    do_reset();
    xb_force = 1'b1;
    rq[2].push_back(32'hFFFF_FFFF);
    step(); step();
    for (int k = 0; k < 3; k++) begin
      chk("t4_x_vld_held", add_one_x_vld, 1);
      chk("t4_x_data_held", add_one_x_data, 32'hFFFF_FFFF);
      chk("t4_no_issue", il_log.size(), 0);
      step();
    end
    xb_force = 1'b0;
    for (int k = 0; k < 100 && !(rl.size() >= 1); k++) step();
    chk("t4_timeout", rl.size() >= 1, 1);
    chk("t4_one_issue", il_log.size(), 1);
    if (rl.size() >= 1) chk("t4_ret", {rl[0], rv[0]}, {2'd2, 32'd0});

    // 5: head lane stalls, later lane must wait
    do_reset();
    rb_force = 4'b0010;
    rq[1].push_back(32'd7); rq[3].push_back(32'd9);
    for (int k = 0; k < 100 && !(il_log.size() >= 2 && add_one_return_vld); k++) step();
    chk("t5_timeout_issue", il_log.size() >= 2, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t5_ret_busy", add_one_return_busy, 1);
      chk("t5_ret_lane1", req_return_vld, 4'b0010);
      chk("t5_none_done", rl.size(), 0);
      step();
    end
    rb_force = '0;
    for (int k = 0; k < 100 && !(rl.size() >= 2); k++) step();
    chk("t5_timeout_ret", rl.size() >= 2, 1);
    if (rl.size() >= 2) begin
      chk("t5_first", {rl[0], rv[0]}, {2'd1, 32'd8});
      chk("t5_second", {rl[1], rv[1]}, {2'd3, 32'd10});
    end

    // 6: reset while issuing with two outstanding
    do_reset();
    rb_force = ONES;
    rq[0].push_back(32'd1); rq[1].push_back(32'd2);
    for (int k = 0; k < 100 && !(outstanding == 2); k++) step();
    chk("t6_occ2", outstanding, 2);
    xb_force = 1'b1;
    rq[2].push_back(32'd3);
    for (int k = 0; k < 20 && !add_one_x_vld; k++) step();
    chk("t6_in_issue", add_one_x_vld, 1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    xb_force = 1'b0;
    rb_force = '0;
    rq[1].push_back(32'd5);
    step();
    clear_logs();
    chk("t6_x_vld", add_one_x_vld, 0);
    chk("t6_x_busy", req_x_busy, ONES);
    chk("t6_ret_vld", req_return_vld, 0);
    chk("t6_ret_busy", add_one_return_busy, 1);
    chk("t6_occ0", outstanding, 0);
    for (int k = 0; k < 100 && !(rl.size() >= 2); k++) step();
    chk("t6_timeout", rl.size() >= 2, 1);
    if (il_log.size() >= 2) begin
      chk("t6_first_grant", il_log[0], 1);
      chk("t6_second_grant", il_log[1], 2);
    end

    // randomized soak: random lanes, operands and back-pressure everywhere
    do_reset();
    rnd = 1'b1;
    total = 300;
    for (int k = 0; k < total; k++) begin
      val = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom);
      rq[$urandom_range(0, N_REQ - 1)].push_back(val);
    end
    for (int k = 0; k < 20000 && !(rl.size() >= total); k++) step();
    chk("rand_all_delivered", rl.size(), total);
    rnd = 1'b0;
    step(); step();
    chk("rand_drained", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/add_one_arbiter.md
Name: add_one_arbiter

Overview:
- Shares one add_one datapath instance among N_REQ requesters.
- Each requester sees its own busy/vld/data request and return channel.
- The arbiter grants the shared x input in round-robin order and records the requester index for each issued operation in an in-order tag FIFO.
- Each add_one result is steered back to the requester at the FIFO head, because add_one returns results strictly in issue order.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, data width of x and return data.
- TAG_DEPTH, 4, maximum outstanding operations inside add_one (power of 2, >=2).

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_x_vld  input  N_REQ  per-requester operand valid.
- req_x_data  input  N_REQ*DW  operands; requester i uses bits [i*DW +: DW].
- req_x_busy  output  N_REQ  per-requester stall.
- req_return_vld  output  N_REQ  per-requester result valid.
- req_return_data  output  DW  result data, broadcast to all requesters; qualified by req_return_vld.
- req_return_busy  input  N_REQ  per-requester result stall.
- add_one_x_vld  output  1  to shared add_one operand channel.
- add_one_x_data  output  DW  operand to add_one.
- add_one_x_busy  input  1  from add_one.
- add_one_return_vld  input  1  from add_one result channel.
- add_one_return_data  input  DW  result from add_one.
- add_one_return_busy  output  1  to add_one.
- outstanding  output  $clog2(TAG_DEPTH+1)  current tag FIFO occupancy.

Behaviour:
Handshake rule (all channels):
- A transfer occurs on a rising clk when vld=1 and busy=0.
- The producer holds vld and data stable until the transfer.
- busy may change in any cycle.

Reset (rst=1 at a clk edge):
- state=IDLE, rr_ptr=0, grant=0, FIFO empty, outstanding=0.
- Resulting outputs: add_one_x_vld=0, req_x_busy=all 1, req_return_vld=0, add_one_return_busy=1.
- Reset mid-operation discards all tags and any granted request. add_one shares rst, so no orphan results remain.

Issue FSM, states IDLE and ISSUE:
- IDLE
  - add_one_x_vld=0; req_x_busy=all 1.
  - If any req_x_vld=1 and outstanding<TAG_DEPTH, register grant = first requester with vld=1, searching from rr_ptr upward with wrap modulo N_REQ. Next state is ISSUE.
  - Requests arriving while the FIFO is full wait in IDLE.
  - The full check uses the registered count, so a pop in the same cycle does not unblock until the next cycle.
- ISSUE
  - add_one_x_vld=1; add_one_x_data=req_x_data slice[grant].
  - req_x_busy[grant]=add_one_x_busy; all other req_x_busy bits=1.
  - On transfer (add_one_x_busy=0): push grant into the FIFO, set rr_ptr=(grant+1) mod N_REQ, next state IDLE.
  - While add_one_x_busy=1, stay in ISSUE with grant and data held.
- Peak issue throughput is one operation per 2 cycles.
- Latency from a requester vld rising to add_one_x_vld is 1 cycle, with an idle arbiter and FIFO not full.

Return path (combinational):
- head = FIFO head tag; empty = (outstanding==0).
- req_return_vld[i] = add_one_return_vld & !empty & (head==i).
- req_return_data = add_one_return_data.
- add_one_return_busy = empty | req_return_busy[head].
- On return transfer, pop the FIFO.
- A result arriving with the FIFO empty is stalled: busy stays 1 and the result is never dropped.

Tag FIFO:
- Width $clog2(N_REQ), depth TAG_DEPTH.
- Read/write pointers wrap modulo TAG_DEPTH.
- Simultaneous push and pop leaves outstanding unchanged and the head advances.
- Push when full cannot occur, because IDLE gates it.
- outstanding is the registered count.

Test Plan:
1. Single requester 1 sends x=5, add_one returns 6 → add_one_x_vld rises 1 cycle after req_x_vld[1]; req_return_vld=4'b0010 with data 6; outstanding goes 0→1→0.
2. Requesters 0, 2 and 3 hold vld with x=10, 20, 30 and the sink never stalls → issue order 0, 2, 3, then 0 again. Returns 11, 21, 31 appear on lanes 0, 2, 3 in that order.
3. req_return_busy=all 1, requester 0 streams 6 operands, TAG_DEPTH=4 → exactly 4 issues, outstanding=4, FSM parked in IDLE with req_x_busy[0]=1. After busy is released, the remaining 2 issue.
4. add_one_x_busy=1 for 3 cycles during ISSUE for requester 2 with x=0xFFFFFFFF → add_one_x_data held stable; one transfer only; result 0x00000000 wraps and is delivered on lane 2.
5. Results pending for lanes 1 then 3, with req_return_busy[1]=1 for 5 cycles → add_one_return_busy=1 and lane 3 is not served until the lane 1 result transfers (in-order steering).
6. Assert rst for 1 cycle while in ISSUE with outstanding=2 → next cycle all outputs are at reset values and outstanding=0. The following request is granted from rr_ptr=0.
